// File: rtl/ps2_pkg.sv
// Shared types and Set-2 scan-code constants for the PS/2 scan-code decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_SPACE  = 8'h29;

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational Set-2 scan code to ASCII lookup: letters, digits, space, enter.
module scancode_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] letter;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        letter = 8'h00;
        ascii  = 8'h00;
        case (code)
            8'h1C: letter = "a";
            8'h32: letter = "b";
            8'h21: letter = "c";
            8'h23: letter = "d";
            8'h24: letter = "e";
            8'h2B: letter = "f";
            8'h34: letter = "g";
            8'h33: letter = "h";
            8'h43: letter = "i";
            8'h3B: letter = "j";
            8'h42: letter = "k";
            8'h4B: letter = "l";
            8'h3A: letter = "m";
            8'h31: letter = "n";
            8'h44: letter = "o";
            8'h4D: letter = "p";
            8'h15: letter = "q";
            8'h2D: letter = "r";
            8'h1B: letter = "s";
            8'h2C: letter = "t";
            8'h3C: letter = "u";
            8'h2A: letter = "v";
            8'h1D: letter = "w";
            8'h22: letter = "x";
            8'h35: letter = "y";
            8'h1A: letter = "z";
            8'h45: ascii  = "0";
            8'h16: ascii  = "1";
            8'h1E: ascii  = "2";
            8'h26: ascii  = "3";
            8'h25: ascii  = "4";
            8'h2E: ascii  = "5";
            8'h36: ascii  = "6";
            8'h3D: ascii  = "7";
            8'h3E: ascii  = "8";
            8'h46: ascii  = "9";
            SC_SPACE: ascii = 8'h20;
            SC_ENTER: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
        // Uppercase is lowercase minus 0x20; only letters react to Shift.
        if (letter != 8'h00) begin
            ascii = shift ? (letter - 8'h20) : letter;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops bytes from the ps2_keyboard FIFO and decodes Set-2 make/break/extended sequences.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [7:0]         ps2_data_in,
    input  logic               ps2_ready,
    input  logic               ps2_overflow,
    output logic               nextdata_n,
    input  logic               clr_ovf,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_valid,
    output logic               shift_held,
    output logic [7:0]         key_ascii,
    output logic               make_pulse,
    output logic               break_pulse,
    output logic [COUNT_W-1:0] key_count,
    output logic               ovf_sticky
);

    state_t     state_q;
    logic [7:0] byte_q;
    logic       ext_pend_q;
    logic       brk_pend_q;
    logic       is_shift;
    logic       is_match;
    logic [7:0] rom_ascii;

    // An E0-prefixed 12/59 is not a Shift key and goes through the normal key path.
    assign is_shift = ((byte_q == SC_LSHIFT) || (byte_q == SC_RSHIFT)) && !ext_pend_q;
    assign is_match = key_valid && (byte_q == key_code) && (ext_pend_q == key_ext);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            byte_q      <= 8'h00;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            nextdata_n  <= 1'b1;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_valid   <= 1'b0;
            shift_held  <= 1'b0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            key_count   <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; pulses default low each cycle.
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;

            if (ps2_overflow) begin
                ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (ps2_ready) begin
                        byte_q     <= ps2_data_in;
                        nextdata_n <= 1'b0;
                        state_q    <= S_POP;
                    end
                end
                S_POP: begin
                    nextdata_n <= 1'b1;
                    state_q    <= S_GAP;
                    if (byte_q == SC_EXT) begin
                        ext_pend_q <= 1'b1;
                    end else if (byte_q == SC_BRK) begin
                        brk_pend_q <= 1'b1;
                    end else begin
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                        if (brk_pend_q) begin
                            if (is_shift) begin
                                shift_held <= 1'b0;
                            end else if (is_match) begin
                                key_valid   <= 1'b0;
                                break_pulse <= 1'b1;
                            end
                        end else if (is_shift) begin
                            shift_held <= 1'b1;
                        end else if (!is_match) begin
                            key_code   <= byte_q;
                            key_ext    <= ext_pend_q;
                            key_valid  <= 1'b1;
                            key_count  <= key_count + COUNT_W'(1);
                            make_pulse <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    nextdata_n <= 1'b1;
                end
            endcase
        end
    end

    scancode_to_ascii u_rom (
        .code  (key_code),
        .shift (shift_held),
        .ascii (rom_ascii)
    );

    assign key_ascii = (key_valid && !key_ext) ? rom_ascii : 8'h00;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench: FIFO model in front of the decoder, scripted and random byte streams vs a reference model.
module tb_ps2_scancode_decoder;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          clrn;
    logic [7:0]    ps2_data_in;
    logic          ps2_ready;
    logic          ps2_overflow;
    logic          nextdata_n;
    logic          clr_ovf;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_valid;
    logic          shift_held;
    logic [7:0]    key_ascii;
    logic          make_pulse;
    logic          break_pulse;
    logic [CW-1:0] key_count;
    logic          ovf_sticky;

    ps2_scancode_decoder #(.COUNT_W(CW)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .ps2_data_in  (ps2_data_in),
        .ps2_ready    (ps2_ready),
        .ps2_overflow (ps2_overflow),
        .nextdata_n   (nextdata_n),
        .clr_ovf      (clr_ovf),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_valid    (key_valid),
        .shift_held   (shift_held),
        .key_ascii    (key_ascii),
        .make_pulse   (make_pulse),
        .break_pulse  (break_pulse),
        .key_count    (key_count),
        .ovf_sticky   (ovf_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int pops = 0, bad_consec = 0, bad_pulse = 0, make_seen = 0, brk_seen = 0;
    bit prev_low = 0, prev_make = 0, prev_brk = 0;
    logic [7:0] fifo [$];

    // Reference model state.
    logic [7:0]    m_code;
    bit            m_ext, m_valid, m_shift, m_epend, m_bpend;
    logic [CW-1:0] m_count;
    int            exp_make = 0, exp_brk = 0;

    byte unsigned letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // FIFO head as ps2_keyboard presents it; pops on an edge with nextdata_n low.
    always @(negedge clk) begin
        ps2_ready   = (fifo.size() != 0);
        ps2_data_in = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    always @(posedge clk) begin
        if (!nextdata_n) begin
            pops++;
            if (prev_low) bad_consec++;
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        prev_low = !nextdata_n;
        if (make_pulse) make_seen++;
        if (break_pulse) brk_seen++;
        if (make_pulse && prev_make) bad_pulse++;
        if (break_pulse && prev_brk) bad_pulse++;
        prev_make = make_pulse;
        prev_brk  = break_pulse;
    end

    function automatic logic [7:0] m_ascii();
        if (!m_valid || m_ext) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (letters[i] == m_code) return 8'((m_shift ? 8'h41 : 8'h61) + i);
        for (int i = 0; i < 10; i++)
            if (digits[i] == m_code) return 8'(8'h30 + i);
        if (m_code == 8'h29) return 8'h20;
        if (m_code == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_code = 8'h00; m_ext = 0; m_valid = 0; m_shift = 0; m_epend = 0; m_bpend = 0; m_count = '0;
    endtask

    task automatic model_step(input logic [7:0] b);
        bit shift_key, same;
        if (b == 8'hE0) m_epend = 1;
        else if (b == 8'hF0) m_bpend = 1;
        else begin
            shift_key = (b == 8'h12 || b == 8'h59) && !m_epend;
            same      = m_valid && (b == m_code) && (m_epend == m_ext);
            if (m_bpend) begin
                if (shift_key) m_shift = 0;
                else if (same) begin m_valid = 0; exp_brk++; end
            end else begin
                if (shift_key) m_shift = 1;
                else if (!same) begin
                    m_code = b; m_ext = m_epend; m_valid = 1; m_count = m_count + 1'b1; exp_make++;
                end
            end
            m_epend = 0; m_bpend = 0;
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0; ps2_overflow = 1'b0; clr_ovf = 1'b0;
        fifo.delete();
        repeat (2) @(negedge clk);
        model_reset();
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int p0;
        bit got;
        p0 = pops; got = 0;
        fifo.push_back(b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pops != p0) begin got = 1; break; end
        end
        if (!got) begin checks++; $display("FAIL pop_timeout byte=%h", b); end
        @(negedge clk);
        model_step(b);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (nextdata_n !== 1'b1) $display("FAIL rst_nextdata got %b want 1", nextdata_n); else passes++;
        checks++; if (key_valid !== 1'b0 || key_code !== 8'h00 || key_ext !== 1'b0)
                      $display("FAIL rst_key got v=%b c=%h e=%b want 0", key_valid, key_code, key_ext); else passes++;
        checks++; if (key_count !== '0 || shift_held !== 1'b0 || ovf_sticky !== 1'b0)
                      $display("FAIL rst_misc got cnt=%h sh=%b ovf=%b want 0", key_count, shift_held, ovf_sticky); else passes++;
        checks++; if (key_ascii !== 8'h00 || make_pulse !== 1'b0 || break_pulse !== 1'b0)
                      $display("FAIL rst_out got a=%h mp=%b bp=%b want 0", key_ascii, make_pulse, break_pulse); else passes++;
    endtask

    task automatic test_basic();
        int p0, m0, b0;
        do_reset();
        p0 = pops; m0 = make_seen; b0 = brk_seen;
        send_byte(8'h1C);
        checks++; if (key_ascii !== 8'h61) $display("FAIL basic_ascii got %h want 61", key_ascii); else passes++;
        checks++; if (make_seen - m0 !== 1) $display("FAIL basic_make got %0d want 1", make_seen - m0); else passes++;
        checks++; if (key_count !== 8'd1) $display("FAIL basic_count got %0d want 1", key_count); else passes++;
        send_byte(8'hF0); send_byte(8'h1C);
        checks++; if (brk_seen - b0 !== 1) $display("FAIL basic_break got %0d want 1", brk_seen - b0); else passes++;
        checks++; if (key_valid !== 1'b0 || key_ascii !== 8'h00)
                      $display("FAIL basic_release got v=%b a=%h want 0/00", key_valid, key_ascii); else passes++;
        checks++; if (pops - p0 !== 3) $display("FAIL basic_pops got %0d want 3", pops - p0); else passes++;
    endtask

    task automatic test_shift();
        logic [7:0] c0;
        do_reset();
        c0 = key_count;
        send_byte(8'h12);
        checks++; if (shift_held !== 1'b1) $display("FAIL shift_set got %b want 1", shift_held); else passes++;
        send_byte(8'h1C);
        checks++; if (key_ascii !== 8'h41) $display("FAIL shift_ascii got %h want 41", key_ascii); else passes++;
        send_byte(8'hF0); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
        checks++; if (8'(key_count - c0) !== 8'd1) $display("FAIL shift_count got %0d want 1", 8'(key_count - c0)); else passes++;
        checks++; if (shift_held !== 1'b0) $display("FAIL shift_clear got %b want 0", shift_held); else passes++;
    endtask

    task automatic test_typematic();
        int m0, b0;
        do_reset();
        m0 = make_seen; b0 = brk_seen;
        repeat (3) send_byte(8'h23);
        checks++; if (make_seen - m0 !== 1 || key_count !== 8'd1)
                      $display("FAIL typematic_make got pulses=%0d cnt=%0d want 1/1", make_seen - m0, key_count); else passes++;
        checks++; if (key_ascii !== 8'h64) $display("FAIL typematic_ascii got %h want 64", key_ascii); else passes++;
        send_byte(8'hF0); send_byte(8'h23);
        checks++; if (brk_seen - b0 !== 1) $display("FAIL typematic_break got %0d want 1", brk_seen - b0); else passes++;
    endtask

    task automatic test_extended();
        int b0;
        do_reset();
        b0 = brk_seen;
        send_byte(8'hE0); send_byte(8'h75);
        checks++; if (key_ext !== 1'b1 || key_valid !== 1'b1 || key_code !== 8'h75)
                      $display("FAIL ext_held got e=%b v=%b c=%h want 1/1/75", key_ext, key_valid, key_code); else passes++;
        checks++; if (key_ascii !== 8'h00) $display("FAIL ext_ascii got %h want 00", key_ascii); else passes++;
        send_byte(8'hF0); send_byte(8'h75);
        checks++; if (key_valid !== 1'b1 || brk_seen - b0 !== 0)
                      $display("FAIL ext_plain_break got v=%b pulses=%0d want 1/0", key_valid, brk_seen - b0); else passes++;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        checks++; if (key_valid !== 1'b0 || brk_seen - b0 !== 1)
                      $display("FAIL ext_release got v=%b pulses=%0d want 0/1", key_valid, brk_seen - b0); else passes++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: b = letters[$urandom_range(0, 25)];
                3:       b = digits[$urandom_range(0, 9)];
                4:       b = 8'hE0;
                5:       b = 8'hF0;
                6:       b = $urandom_range(0, 1) ? 8'h12 : 8'h59;
                7:       b = $urandom_range(0, 1) ? 8'h29 : 8'h5A;
                8:       b = 8'($urandom_range(0, 255));
                default: b = m_code;
            endcase
            send_byte(b);
            checks++;
            if (key_valid !== m_valid || key_ext !== m_ext || shift_held !== m_shift || (m_valid && key_code !== m_code))
                $display("FAIL rand_state n=%0d b=%h got v=%b e=%b s=%b c=%h want v=%b e=%b s=%b c=%h",
                         n, b, key_valid, key_ext, shift_held, key_code, m_valid, m_ext, m_shift, m_code);
            else passes++;
            checks++;
            if (key_ascii !== m_ascii() || key_count !== m_count)
                $display("FAIL rand_out n=%0d b=%h got a=%h cnt=%0d want a=%h cnt=%0d",
                         n, b, key_ascii, key_count, m_ascii(), m_count);
            else passes++;
            checks++;
            if (make_seen !== exp_make || brk_seen !== exp_brk)
                $display("FAIL rand_pulses n=%0d got mk=%0d bk=%0d want mk=%0d bk=%0d",
                         n, make_seen, brk_seen, exp_make, exp_brk);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        int m0;
        do_reset();
        m0 = make_seen;
        for (int i = 0; i < 256; i++) send_byte((i % 2 == 0) ? 8'h16 : 8'h1E);
        checks++; if (key_count !== 8'h00) $display("FAIL wrap_count got %h want 00", key_count); else passes++;
        checks++; if (make_seen - m0 !== 256) $display("FAIL wrap_pulses got %0d want 256", make_seen - m0); else passes++;
        checks++; if (key_ascii !== 8'h32) $display("FAIL wrap_ascii got %h want 32", key_ascii); else passes++;
    endtask

    task automatic test_overflow();
        do_reset();
        ps2_overflow = 1'b1; @(negedge clk); ps2_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ovf_sticky !== 1'b1) $display("FAIL ovf_hold got %b want 1", ovf_sticky); else passes++;
        ps2_overflow = 1'b1; clr_ovf = 1'b1; @(negedge clk); ps2_overflow = 1'b0; clr_ovf = 1'b0;
        checks++; if (ovf_sticky !== 1'b1) $display("FAIL ovf_set_wins got %b want 1", ovf_sticky); else passes++;
        clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf_sticky); else passes++;
    endtask

    task automatic test_reset_mid_pop();
        int p0;
        bit got;
        do_reset();
        send_byte(8'h1C);
        ps2_overflow = 1'b1; @(negedge clk); ps2_overflow = 1'b0;
        p0 = pops; got = 0;
        fifo.push_back(8'h1E);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (nextdata_n === 1'b0) begin got = 1; break; end
        end
        checks++; if (!got) $display("FAIL midpop_timeout got no pop strobe"); else passes++;
        #1 clrn = 1'b0;
        #1;
        checks++; if (nextdata_n !== 1'b1) $display("FAIL midpop_nextdata got %b want 1", nextdata_n); else passes++;
        checks++; if (key_valid !== 1'b0 || key_count !== '0 || ovf_sticky !== 1'b0 || key_ascii !== 8'h00)
                      $display("FAIL midpop_outputs got v=%b cnt=%h ovf=%b a=%h want 0", key_valid, key_count, ovf_sticky, key_ascii);
                  else passes++;
        fifo.delete();
        repeat (2) @(negedge clk);
        model_reset();
        clrn = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (pops !== p0) $display("FAIL midpop_no_pop got %0d want %0d", pops, p0); else passes++;
    endtask

    task automatic test_protocol();
        checks++; if (bad_consec !== 0) $display("FAIL proto_consec_pop got %0d want 0", bad_consec); else passes++;
        checks++; if (bad_pulse !== 0) $display("FAIL proto_pulse_width got %0d want 0", bad_pulse); else passes++;
    endtask

    initial begin
        clrn = 1'b0; ps2_overflow = 1'b0; clr_ovf = 1'b0;
        ps2_ready = 1'b0; ps2_data_in = 8'h00;
        test_reset();
        test_basic();
        test_shift();
        test_typematic();
        test_extended();
        test_random();
        test_wrap();
        test_overflow();
        test_reset_mid_pop();
        test_protocol();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of ps2_keyboard and consumes its byte FIFO through the data/ready/nextdata_n handshake.
- Parses PS/2 Set-2 scan-code sequences: make, break (F0 prefix) and extended (E0 prefix).
- Tracks the currently held key and the Shift state, and produces an ASCII code, make/break event pulses and a press counter for display logic.

Parameters:
- COUNT_W, 8, width of the key-press counter; wraps modulo 2^COUNT_W.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- clrn  in  1  asynchronous, active-low reset.
- ps2_data_in  in  8  FIFO head byte from ps2_keyboard (its data output).
- ps2_ready  in  1  FIFO non-empty from ps2_keyboard.
- ps2_overflow  in  1  FIFO overflow flag from ps2_keyboard.
- nextdata_n  out  1  active-low pop strobe to ps2_keyboard; registered.
- clr_ovf  in  1  clears ovf_sticky.
- key_code  out  8  scan code of the held non-Shift key.
- key_ext  out  1  held key was E0-prefixed.
- key_valid  out  1  a non-Shift key is held.
- shift_held  out  1  left (12) or right (59) Shift is held.
- key_ascii  out  8  ASCII of the held key; 0x00 if none or unmapped.
- make_pulse  out  1  one-cycle pulse on a new key press.
- break_pulse  out  1  one-cycle pulse on release of the held key.
- key_count  out  COUNT_W  number of new non-Shift presses.
- ovf_sticky  out  1  latched ps2_overflow.

Behaviour:
- Reset (clrn=0, async):
  - nextdata_n=1.
  - key_code, key_ext, key_valid, shift_held, make_pulse, break_pulse, key_count, ovf_sticky and all internal prefix flags = 0.
  - FSM returns to S_IDLE.
  - Reset mid-handshake abandons the byte. It is not popped unless nextdata_n was already low at the preceding edge.
- FSM states: S_IDLE, S_POP, S_GAP.
  - S_IDLE: if ps2_ready=1, capture ps2_data_in into byte_r and go to S_POP.
  - S_POP: nextdata_n=0 for exactly this cycle, and the FIFO pops on this edge. The byte in byte_r is decoded on this same edge, so all state and pulse updates become visible in the S_GAP cycle. Then go to S_GAP.
  - S_GAP: nextdata_n=1. Waits one cycle so ps2_ready/ps2_data_in reflect the new FIFO head. Then go to S_IDLE.
  - Throughput: 1 byte per 3 cycles. nextdata_n is never low in two consecutive cycles.
- Decode rules (per byte):
  - E0: set ext_pend. No event.
  - F0: set brk_pend. No event.
  - Any other byte b: acts as code; ext_pend and brk_pend are cleared afterwards.
    - Break (brk_pend=1):
      - b=12 or 59 with ext_pend=0: shift_held=0.
      - Else, if key_valid and b==key_code and ext_pend==key_ext: key_valid=0 and break_pulse=1.
      - Otherwise ignored.
    - Make (brk_pend=0):
      - b=12 or 59 with ext_pend=0: shift_held=1; no count.
      - Else, if key_valid and b==key_code and ext_pend==key_ext: typematic repeat; no change, no pulse.
      - Else: key_code=b, key_ext=ext_pend, key_valid=1, key_count+=1 (wraps all-ones to 0), make_pulse=1.
      - A new key while another is held replaces it; no break_pulse for the old key.
- Pulses: make_pulse and break_pulse are high for exactly one cycle.
- key_ascii: combinational from registered key_code, key_ext, shift_held, key_valid.
  - 0x00 if key_valid=0 or key_ext=1.
  - Letters: lowercase; uppercase when shift_held.
  - Digits 0-9: digit code; Shift has no effect.
  - Space 29 -> 0x20; Enter 5A -> 0x0D.
  - Unmapped -> 0x00.
- ovf_sticky:
  - Set on any cycle with ps2_overflow=1.
  - Cleared by clr_ovf=1.
  - If both occur in the same cycle, set wins.

Decomposition:
- Package ps2_pkg:
  - state enum.
  - Constants SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_ENTER=5A, SC_SPACE=29.
- Sub-module scancode_to_ascii: combinational ROM with inputs code[7:0], shift and output ascii[7:0]. Covers all 26 letters (1C='a', 32='b', 21='c', 23='d', 24='e', ...), digits 45,16,1E,26,25,2E,36,3D,3E,46 ('0'-'9'), space and enter.

Test Plan:
- Reset then FIFO bytes 1C, F0, 1C:
  - Exactly 3 pops, each nextdata_n low 1 cycle and never consecutive.
  - key_ascii=0x61 while held; make_pulse once; key_count=1.
  - Then break_pulse once, key_valid=0, key_ascii=0x00.
- Bytes 12, 1C, F0, 1C, F0, 12:
  - shift_held=1 then key_ascii=0x41.
  - key_count increments only for 1C (=1); shift_held=0 at end.
- Typematic 23, 23, 23, F0, 23:
  - One make_pulse; key_count=1; one break_pulse.
- Extended E0, 75, F0, 75 (plain, no E0, on release):
  - key_ext=1, key_ascii=0x00.
  - Plain F0 75 does not match the held key: no break_pulse, key_valid stays 1.
  - Then E0, F0, 75 releases it.
- Counter wrap, COUNT_W=8: 256 distinct alternating presses 16, 1E -> key_count returns to 0x00.
- Overflow and reset:
  - ps2_overflow pulse -> ovf_sticky=1 until clr_ovf.
  - Assert clrn=0 during S_POP -> all outputs 0 immediately, nextdata_n=1 asynchronously.
